// File: rtl/ocimem_access_engine.sv
// ocimem_access_engine: turns debug-slave ocimem strobes into single-word accesses on the debug memory port
module ocimem_access_engine #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    state_t            state;
    logic              inc;
    logic [TO_W-1:0]   cnt;
    logic [ADDR_W-1:0] jdo_addr;
    logic              strobe;
    logic              unused_jdo;
    assign jdo_addr   = jdo[ADDR_W+16:17];
    assign strobe     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
    // Command decode in IDLE; request hold, completion, stall timeout and busy-strobe errors otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            inc           <= 1'b0;
            cnt           <= '0;
            MonAReg       <= '0;
            MonDReg       <= '0;
            mem_address   <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            busy          <= 1'b0;
        end else if (state == IDLE) begin
            if (take_action_ocimem_b) begin
                MonDReg       <= jdo[34:3];
                mem_writedata <= jdo[34:3];
                mem_address   <= MonAReg;
                mem_write     <= 1'b1;
                busy          <= 1'b1;
                monitor_ready <= 1'b0;
                cnt           <= '0;
                inc           <= 1'b1;
                state         <= WR;
            end else if (take_action_ocimem_a) begin
                MonAReg <= jdo_addr;
                if (jdo[35]) monitor_error <= 1'b0;
                if (jdo[34]) begin
                    mem_address   <= jdo_addr;
                    mem_read      <= 1'b1;
                    busy          <= 1'b1;
                    monitor_ready <= 1'b0;
                    cnt           <= '0;
                    inc           <= 1'b0;
                    state         <= RD;
                end
            end else if (take_no_action_ocimem_a) begin
                mem_address   <= MonAReg;
                mem_read      <= 1'b1;
                busy          <= 1'b1;
                monitor_ready <= 1'b0;
                cnt           <= '0;
                inc           <= 1'b1;
                state         <= RD;
            end
        end else begin
            if (strobe) monitor_error <= 1'b1;
            if (!mem_waitrequest) begin
                mem_read      <= 1'b0;
                mem_write     <= 1'b0;
                if (state == RD) MonDReg <= mem_readdata;
                if (inc) MonAReg <= MonAReg + ADDR_W'(1);
                monitor_ready <= 1'b1;
                busy          <= 1'b0;
                state         <= IDLE;
            end else if (cnt == TO_W'(TIMEOUT)) begin
                mem_read      <= 1'b0;
                mem_write     <= 1'b0;
                monitor_error <= 1'b1;
                monitor_ready <= 1'b1;
                busy          <= 1'b0;
                state         <= IDLE;
            end else begin
                cnt <= cnt + TO_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ocimem_access_engine.sv
// tb_ocimem_access_engine: directed stimulus checked every cycle against a transaction-level model
module tb_ocimem_access_engine;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 255;
    localparam int TO_W    = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [37:0]       jdo = '0;
    logic              take_action_ocimem_a = 1'b0;
    logic              take_no_action_ocimem_a = 1'b0;
    logic              take_action_ocimem_b = 1'b0;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata = '0;
    logic              mem_waitrequest = 1'b0;
    logic [31:0]       MonDReg;
    logic [ADDR_W-1:0] MonAReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic              busy;

    ocimem_access_engine #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest), .MonDReg(MonDReg), .MonAReg(MonAReg),
        .monitor_ready(monitor_ready), .monitor_error(monitor_error), .busy(busy)
    );

    always #5 clk = ~clk;

    // Transaction-level model: acc 0=none 1=read 2=write
    int          m_a, acc, acc_addr, stalls;
    logic [31:0] m_d, m_wd;
    bit          m_err, m_rdy, acc_inc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_a = 0; m_d = 0; m_wd = 0; m_err = 0; m_rdy = 1;
            acc = 0; acc_addr = 0; acc_inc = 0; stalls = 0;
        end else if (acc == 0) begin
            if (take_action_ocimem_b) begin
                m_d = jdo[34:3]; m_wd = jdo[34:3];
                acc = 2; acc_addr = m_a; acc_inc = 1; stalls = 0; m_rdy = 0;
            end else if (take_action_ocimem_a) begin
                m_a = int'(jdo[ADDR_W+16:17]);
                if (jdo[35]) m_err = 0;
                if (jdo[34]) begin
                    acc = 1; acc_addr = m_a; acc_inc = 0; stalls = 0; m_rdy = 0;
                end
            end else if (take_no_action_ocimem_a) begin
                acc = 1; acc_addr = m_a; acc_inc = 1; stalls = 0; m_rdy = 0;
            end
        end else begin
            if (take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b) m_err = 1;
            if (!mem_waitrequest) begin
                if (acc == 1) m_d = mem_readdata;
                if (acc_inc) m_a = (m_a + 1) % (1 << ADDR_W);
                acc = 0; m_rdy = 1;
            end else begin
                stalls++;
                if (stalls > TIMEOUT) begin
                    acc = 0; m_err = 1; m_rdy = 1;
                end
            end
        end
    end

    int total = 0;
    int bad = 0;
    int rd_cyc = 0;
    int wr_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("mem_read", 32'(mem_read), 32'(acc == 1));
        chk("mem_write", 32'(mem_write), 32'(acc == 2));
        chk("busy", 32'(busy), 32'(acc != 0));
        chk("mem_address", 32'(mem_address), 32'(acc_addr));
        chk("mem_writedata", mem_writedata, m_wd);
        chk("MonDReg", MonDReg, m_d);
        chk("MonAReg", 32'(MonAReg), 32'(m_a));
        chk("monitor_ready", 32'(monitor_ready), 32'(m_rdy));
        chk("monitor_error", 32'(monitor_error), 32'(m_err));
        chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
    endtask

    task automatic tick();
        @(negedge clk);
        if (mem_read) rd_cyc++;
        if (mem_write) wr_cyc++;
        cmp_model();
    endtask

    function automatic logic [37:0] jdo_a(input int addr, input bit rd, input bit clr);
        logic [37:0] j = '0;
        j[ADDR_W+16:17] = ADDR_W'(addr);
        j[34] = rd;
        j[35] = clr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic strobe(input bit a, input bit na, input bit b, input logic [37:0] j);
        jdo = j;
        take_action_ocimem_a = a;
        take_no_action_ocimem_a = na;
        take_action_ocimem_b = b;
        tick();
        take_action_ocimem_a = 0;
        take_no_action_ocimem_a = 0;
        take_action_ocimem_b = 0;
    endtask

    task automatic wait_ready(input int lim);
        int n = 0;
        while (!(monitor_ready && !busy) && n < lim) begin
            tick();
            n++;
        end
        chk("ready_in_time", 32'(monitor_ready && !busy), 32'd1);
    endtask

    initial begin
        int r0, w0;
        tick();
        tick();
        reset = 0;
        tick();
        chk("rst_MonAReg", 32'(MonAReg), 32'h0);
        chk("rst_MonDReg", MonDReg, 32'h0);
        chk("rst_ready", 32'(monitor_ready), 32'h1);
        chk("rst_error", 32'(monitor_error), 32'h0);

        // load-and-read at 0x12, zero wait
        mem_readdata = 32'hDEADBEEF;
        r0 = rd_cyc;
        strobe(1, 0, 0, jdo_a(8'h12, 1, 0));
        chk("t1_read_hi", 32'(mem_read), 32'h1);
        chk("t1_addr", 32'(mem_address), 32'h12);
        chk("t1_not_ready", 32'(monitor_ready), 32'h0);
        tick();
        chk("t1_ready_n2", 32'(monitor_ready), 32'h1);
        chk("t1_dreg", MonDReg, 32'hDEADBEEF);
        chk("t1_areg", 32'(MonAReg), 32'h12);
        chk("t1_rd_cycles", 32'(rd_cyc - r0), 32'd1);

        // write at 0xFF with 3 stall cycles, address wraps
        strobe(1, 0, 0, jdo_a(8'hFF, 0, 0));
        mem_waitrequest = 1;
        w0 = wr_cyc;
        strobe(0, 0, 1, jdo_b(32'h0000_00A5));
        repeat (3) tick();
        mem_waitrequest = 0;
        wait_ready(10);
        chk("t2_wr_cycles", 32'(wr_cyc - w0), 32'd4);
        chk("t2_wdata", mem_writedata, 32'hA5);
        chk("t2_areg_wrap", 32'(MonAReg), 32'h0);
        chk("t2_error", 32'(monitor_error), 32'h0);

        // three streaming reads from 0x10
        strobe(1, 0, 0, jdo_a(8'h10, 0, 0));
        for (int i = 1; i <= 3; i++) begin
            mem_readdata = 32'(i);
            strobe(0, 1, 0, '0);
            wait_ready(10);
            chk("t3_dreg_seq", MonDReg, 32'(i));
        end
        chk("t3_areg_end", 32'(MonAReg), 32'h13);

        // stuck read times out after TIMEOUT+1 stall cycles
        mem_waitrequest = 1;
        r0 = rd_cyc;
        strobe(0, 1, 0, '0);
        wait_ready(400);
        chk("t4_rd_cycles", 32'(rd_cyc - r0), 32'd256);
        chk("t4_error", 32'(monitor_error), 32'h1);
        chk("t4_ready", 32'(monitor_ready), 32'h1);
        chk("t4_areg", 32'(MonAReg), 32'h13);
        chk("t4_read_lo", 32'(mem_read), 32'h0);
        chk("t4_dreg", MonDReg, 32'h3);
        mem_waitrequest = 0;
        strobe(1, 0, 0, jdo_a(8'h13, 0, 1));
        chk("t4_err_clear", 32'(monitor_error), 32'h0);

        // write strobe during a stalled read is ignored and flags an error
        mem_waitrequest = 1;
        mem_readdata = 32'h5555AAAA;
        w0 = wr_cyc;
        strobe(0, 1, 0, '0);
        tick();
        strobe(0, 0, 1, jdo_b(32'h77));
        tick();
        mem_waitrequest = 0;
        wait_ready(10);
        chk("t5_no_write", 32'(wr_cyc - w0), 32'd0);
        chk("t5_error", 32'(monitor_error), 32'h1);
        chk("t5_dreg", MonDReg, 32'h5555AAAA);
        chk("t5_areg", 32'(MonAReg), 32'h14);
        chk("t5_wdata_kept", mem_writedata, 32'hA5);

        // async reset mid-write, then simultaneous a+b strobes
        mem_waitrequest = 1;
        strobe(0, 0, 1, jdo_b(32'h3C));
        chk("t6_write_hi", 32'(mem_write), 32'h1);
        #2 reset = 1;
        #1;
        chk("t6_write_drop", 32'(mem_write), 32'h0);
        chk("t6_areg", 32'(MonAReg), 32'h0);
        chk("t6_dreg", MonDReg, 32'h0);
        chk("t6_ready", 32'(monitor_ready), 32'h1);
        chk("t6_busy", 32'(busy), 32'h0);
        cmp_model();
        tick();
        reset = 0;
        mem_waitrequest = 0;
        r0 = rd_cyc;
        w0 = wr_cyc;
        strobe(1, 0, 1, jdo_a(8'h20, 1, 0));
        wait_ready(10);
        chk("t6_prio_rd", 32'(rd_cyc - r0), 32'd0);
        chk("t6_prio_wr", 32'(wr_cyc - w0), 32'd1);
        chk("t6_prio_dreg", MonDReg, 32'h8008_0000);
        chk("t6_prio_areg", 32'(MonAReg), 32'h1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ocimem_access_engine.md
Name: ocimem_access_engine

Overview:
- Consumes the debug-slave sysclk outputs (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a) and turns them into single-word transactions on a 32-bit Avalon-style port into the on-chip debug memory.
- Returns MonDReg, monitor_ready and monitor_error, which feed back into the debug slave TCK scan chain.
- Holds the monitor address register, auto-increments on streaming reads and writes, and aborts stalled accesses with a timeout.

Parameters:
- ADDR_W, 8, word-address width of the debug memory; legal range 1..17.
- TIMEOUT, 255, maximum consecutive waitrequest cycles before an access is aborted; must be at least 1.
- TO_W, 8, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- jdo  in  38  debug-slave data word; sampled only in a strobe cycle.
- take_action_ocimem_a  in  1  one-cycle strobe: load address, with optional read and optional error clear.
- take_no_action_ocimem_a  in  1  one-cycle strobe: streaming read at MonAReg.
- take_action_ocimem_b  in  1  one-cycle strobe: streaming write at MonAReg.
- mem_address  out  ADDR_W  word address.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- mem_writedata  out  32  write data.
- mem_readdata  in  32  read data; valid when mem_read=1 and mem_waitrequest=0.
- mem_waitrequest  in  1  slave stall.
- MonDReg  out  32  monitor data register.
- MonAReg  out  ADDR_W  monitor address register.
- monitor_ready  out  1  last command finished.
- monitor_error  out  1  sticky error flag.
- busy  out  1  access in progress.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; MonAReg=0; MonDReg=0.
  - mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
  - monitor_ready=1, monitor_error=0, busy=0, timeout counter=0.
  - Asserting reset mid-access drops mem_read and mem_write immediately, with no completion.
- jdo fields:
  - Address: jdo[ADDR_W+16:17].
  - Read-after-load: jdo[34], action_a only.
  - Clear error: jdo[35], action_a only.
  - Write data: jdo[34:3], action_b only.
- Strobe priority when several are high in the same cycle: action_b > action_a > no_action_a. The lower-priority strobes are discarded.
- FSM states: IDLE, RD, WR.
- IDLE, action_a:
  - MonAReg <= address field.
  - If jdo[35]=1: monitor_error <= 0.
  - If jdo[34]=1: go to RD at the new address, no post-increment.
  - Otherwise: stay in IDLE; monitor_ready stays 1.
- IDLE, no_action_a: go to RD at MonAReg, post-increment on completion.
- IDLE, action_b: MonDReg <= jdo[34:3], mem_writedata <= jdo[34:3]; go to WR at MonAReg, post-increment on completion.
- Entering RD or WR:
  - Registered: the request is asserted on the cycle after the strobe.
  - mem_address <= target address; busy <= 1; monitor_ready <= 0; timeout counter <= 0.
- RD/WR each cycle with mem_waitrequest=1: counter increments.
- RD/WR, completion edge (mem_waitrequest=0):
  - Deassert the request on the next cycle.
  - RD: MonDReg <= mem_readdata.
  - If post-increment applies: MonAReg <= MonAReg+1 mod 2^ADDR_W (all-ones wraps to 0).
  - state=IDLE; monitor_ready <= 1; busy <= 0.
  - Minimum latency: strobe at cycle N, request high in N+1, monitor_ready=1 in N+2.
- Timeout: if waitrequest is still 1 after the counter reaches TIMEOUT:
  - Abort: deassert the request, monitor_error <= 1, monitor_ready <= 1, go to IDLE.
  - MonDReg and MonAReg are unchanged; a write-loaded MonDReg keeps its loaded value.
- Any strobe received while busy=1:
  - Ignored; monitor_error <= 1 (sticky).
  - The in-flight access continues unaffected.
- monitor_error clears only on reset or on action_a with jdo[35]=1. An action_a that also sets an error in the same cycle is not possible because it is only accepted in IDLE.
- mem_read and mem_write are never high at the same time.
- Request and address are held stable while waitrequest=1.

Test Plan:
- Reset, then action_a with address field=0x12, jdo[34]=1, mem_readdata=0xDEADBEEF, waitrequest=0 -> mem_read high for 1 cycle at address 0x12; MonDReg=0xDEADBEEF; MonAReg stays 0x12; monitor_ready=1 two cycles after the strobe.
- action_b with data 0x0000_00A5 at MonAReg=0xFF, waitrequest high 3 cycles -> mem_write held 4 cycles with address 0xFF and data 0xA5; MonAReg wraps to 0x00; monitor_error=0.
- Three back-to-back no_action_a reads, each issued after ready, from address 0x10 with readdata 1,2,3 -> MonDReg sequence 1,2,3; MonAReg ends at 0x13.
- Read with waitrequest stuck at 1, TIMEOUT=255 -> abort after 256 stall cycles; monitor_error=1, monitor_ready=1, MonAReg unchanged, mem_read=0. Then action_a with jdo[35]=1 -> monitor_error=0.
- Issue action_b while a read is stalled -> write ignored; no mem_write pulse; monitor_error=1; read completes with correct MonDReg.
- Assert reset while mem_write=1 -> mem_write=0 without waiting for a clock edge; all outputs return to reset values; action_a and action_b asserted in the same cycle -> only the write executes.
